// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one Uart8 transmitter among NUM_REQ byte producers.
// It grants one byte per frame, then waits for txDone or a watchdog timeout, and then an optional gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 15000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         reqValid,
  input  logic [8*NUM_REQ-1:0]       reqData,
  output logic [NUM_REQ-1:0]         reqReady,
  output logic [$clog2(NUM_REQ)-1:0] grantId,
  output logic                       busy,
  output logic                       timeoutErr,
  output logic                       txEn,
  output logic                       txStart,
  output logic [7:0]                 txByte,
  input  logic                       txBusy,
  input  logic                       txDone
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} stateT;

  stateT            state, stateNext;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gapCnt;
  logic [IDX_W-1:0] rrPtr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   cand;
  logic             anyWin;
  logic             frameEnd;
  logic             grantNow;

  // txBusy is status only; sequencing relies on txDone alone
  logic unusedTxBusy;
  assign unusedTxBusy = txBusy;

  // Search rrPtr+1, rrPtr+2, ... (mod NUM_REQ) for the first pending request
  always_comb begin
    winner = '0;
    anyWin = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rrPtr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!anyWin && reqValid[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        anyWin = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    timeoutErr = 1'b0;
    frameEnd   = 1'b0;
    grantNow   = 1'b0;
    case (state)
      IDLE: begin
        if (en && anyWin) begin
          grantNow  = 1'b1;
          stateNext = LAUNCH;
        end
      end
      LAUNCH: stateNext = WAIT_DONE;
      WAIT_DONE: begin
        // txDone takes priority over a timeout landing on the same cycle
        if (txDone) begin
          frameEnd = 1'b1;
        end else if (timer == TMR_LAST) begin
          frameEnd   = 1'b1;
          timeoutErr = 1'b1;
        end
        if (frameEnd) stateNext = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: if (gapCnt == GAP_LAST) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign txStart  = (state == LAUNCH);
  assign reqReady = NUM_REQ'(txStart) << grantId;
  assign busy     = (state != IDLE);
  assign txEn     = en | busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      gapCnt  <= '0;
      rrPtr   <= IDX_W'(NUM_REQ - 1);
      grantId <= '0;
      txByte  <= '0;
    end else begin
      state <= stateNext;
      if (grantNow) begin
        grantId <= winner;
        rrPtr   <= winner;
        txByte  <= reqData[{winner, 3'b000} +: 8];
      end
      // Timer saturates rather than wrapping
      if (state == LAUNCH) timer <= '0;
      else if (state == WAIT_DONE && timer != TMR_MAX) timer <= timer + TMR_W'(1);
      if (state == GAP) gapCnt <= gapCnt + GAP_W'(1);
      else gapCnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no gap / 5-cycle gap) driven by Uart8 txDone stubs,
// checked by a timestamp-based reference model, a grant-order table and directed corner sequences.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TOUT = 40;
  localparam int GAPB = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  reqValid = '0;
  logic [31:0] reqData = '0;
  logic [1:0]  txDone = '0;
  logic [1:0]  txBusy = '0;

  logic [1:0][3:0] rdy;
  logic [1:0][1:0] gid;
  logic [1:0][7:0] txb;
  logic [1:0]      bsy, tmo, ten, tst;

  int  nCmp = 0;
  int  nBad = 0;
  int  cyc = 0;
  int  stubLen[2];
  int  stubCnt[2];
  logic [1:0] stale = '0;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TOUT)) dutA (
    .clk(clk), .reset(reset), .en(en), .reqValid(reqValid), .reqData(reqData),
    .reqReady(rdy[0]), .grantId(gid[0]), .busy(bsy[0]), .timeoutErr(tmo[0]),
    .txEn(ten[0]), .txStart(tst[0]), .txByte(txb[0]), .txBusy(txBusy[0]), .txDone(txDone[0])
  );

  uart_tx_arbiter #(.NUM_REQ(NREQ), .GAP_CYCLES(GAPB), .TIMEOUT_CYCLES(TOUT)) dutB (
    .clk(clk), .reset(reset), .en(en), .reqValid(reqValid), .reqData(reqData),
    .reqReady(rdy[1]), .grantId(gid[1]), .busy(bsy[1]), .timeoutErr(tmo[1]),
    .txEn(ten[1]), .txStart(tst[1]), .txByte(txb[1]), .txBusy(txBusy[1]), .txDone(txDone[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic sig(input int kind, input int i);
    case (kind)
      0: return tst[i];
      1: return txDone[i];
      default: return tmo[i];
    endcase
  endfunction

  task automatic waitSig(input int kind, input int i, input int lim, output int n);
    n = 0;
    while (!sig(kind, i) && n < lim) begin
      tick();
      n++;
    end
    if (!sig(kind, i)) begin
      nCmp++;
      nBad++;
      $display("FAIL wait(kind %0d) dut%0d: event not seen within %0d cycles", kind, i, lim);
    end
  endtask

  task automatic waitIdle(input int i, input int lim);
    int n;
    n = 0;
    while (bsy[i] !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
    if (bsy[i] !== 1'b0) begin
      nCmp++;
      nBad++;
      $display("FAIL waitIdle dut%0d: busy=%0b after %0d cycles, expected 0", i, bsy[i], lim);
    end
  endtask

  // Uart8 stand-in: txDone pulses stubLen cycles after txStart (0 = random length, -1 = never)
  initial begin
    stubCnt = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        txDone[i] = 1'b0;
        if (tst[i]) begin
          stubCnt[i] = (stubLen[i] == 0) ? int'($urandom_range(1, 45)) : stubLen[i];
          if (stale[i]) txDone[i] = 1'b1;
        end else if (stubCnt[i] > 0) begin
          stubCnt[i]--;
          if (stubCnt[i] == 0) txDone[i] = 1'b1;
        end
        txBusy[i] = (stubCnt[i] > 0);
      end
    end
  end

  // Reference model: a frame is a launch timestamp plus an end timestamp; idle again gap cycles after the end
  int   mBusy[2], mLaunch[2], mEnd[2], mGrant[2], mPtr[2];
  logic [7:0] mByte[2];
  int   gapOf[2];
  logic eStart, eTmo;
  int   w, idx;

  initial begin
    gapOf = '{0, GAPB};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          mBusy[i] = 0; mLaunch[i] = -1; mEnd[i] = -1;
          mGrant[i] = 0; mPtr[i] = NREQ - 1; mByte[i] = 8'h00;
        end
        eStart = (mBusy[i] != 0) && (cyc == mLaunch[i]);
        eTmo   = (mBusy[i] != 0) && (mEnd[i] < 0) && (cyc > mLaunch[i]) && !txDone[i] &&
                 ((cyc - mLaunch[i]) == TOUT);
        chk("txStart", i, tst[i], eStart);
        chk("reqReady", i, rdy[i], eStart ? (32'd1 << mGrant[i]) : 32'd0);
        chk("busy", i, bsy[i], mBusy[i] != 0);
        chk("timeoutErr", i, tmo[i], eTmo);
        chk("txEn", i, ten[i], en | (mBusy[i] != 0));
        chk("grantId", i, gid[i], mGrant[i]);
        chk("txByte", i, txb[i], mByte[i]);
        if (!reset) begin
          if (mBusy[i] == 0) begin
            if (en && reqValid != 0) begin
              w = -1;
              for (int k = 1; k <= NREQ; k++) begin
                idx = (mPtr[i] + k) % NREQ;
                if (w < 0 && reqValid[idx]) w = idx;
              end
              mBusy[i] = 1; mLaunch[i] = cyc + 1; mEnd[i] = -1;
              mGrant[i] = w; mPtr[i] = w; mByte[i] = reqData[8*w +: 8];
            end
          end else begin
            if (mEnd[i] < 0 && cyc > mLaunch[i] && (txDone[i] || (cyc - mLaunch[i]) == TOUT))
              mEnd[i] = cyc;
            if (mEnd[i] >= 0 && cyc + 1 >= mEnd[i] + 1 + gapOf[i]) mBusy[i] = 0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          expId;
    logic [7:0]  expByte;
  } vecT;

  vecT tbl[12];

  initial begin
    int n;
    int pulses;
    tbl[0]  = '{4'b1111, 32'h44332211, 0, 8'h11};
    tbl[1]  = '{4'b1111, 32'h44332211, 1, 8'h22};
    tbl[2]  = '{4'b1111, 32'h44332211, 2, 8'h33};
    tbl[3]  = '{4'b1111, 32'h44332211, 3, 8'h44};
    tbl[4]  = '{4'b1111, 32'h44332211, 0, 8'h11};
    tbl[5]  = '{4'b1010, 32'hD4C3B2A1, 1, 8'hB2};
    tbl[6]  = '{4'b1010, 32'hD4C3B2A1, 3, 8'hD4};
    tbl[7]  = '{4'b1010, 32'hD4C3B2A1, 1, 8'hB2};
    tbl[8]  = '{4'b0100, 32'h00B50000, 2, 8'hB5};
    tbl[9]  = '{4'b0001, 32'h000000E7, 0, 8'hE7};
    tbl[10] = '{4'b1001, 32'h9C00007E, 3, 8'h9C};
    tbl[11] = '{4'b1001, 32'h9C00007E, 0, 8'h7E};
    stubLen = '{6, 6};

    repeat (3) tick();
    chk("rstBusy", 0, bsy[0], 0);
    chk("rstTxStart", 0, tst[0], 0);
    chk("rstReqReady", 0, rdy[0], 0);
    chk("rstGrantId", 0, gid[0], 0);
    chk("rstTxByte", 0, txb[0], 0);
    chk("rstTxEn", 0, ten[0], 0);
    reset = 1'b0;
    en = 1'b1;
    tick();

    // Grant order table, including wrap-around search
    for (int r = 0; r < 12; r++) begin
      waitIdle(0, 100);
      reqValid = tbl[r].valid;
      reqData  = tbl[r].data;
      tick();
      chk("tblLatency", 0, tst[0], 1);
      chk("tblGrantId", 0, gid[0], tbl[r].expId);
      chk("tblTxByte", 0, txb[0], tbl[r].expByte);
      chk("tblReqReady", 0, rdy[0], 32'd1 << tbl[r].expId);
      reqValid = '0;
    end

    // Back-to-back frames: no gap on A, 5-cycle gap on B
    waitIdle(0, 100);
    reqValid = 4'b1111;
    reqData  = 32'h5A6B7C8D;
    waitSig(0, 0, 5, n);
    waitSig(1, 0, 20, n);
    tick();
    chk("busyFallAfterDone", 0, bsy[0], 0);
    tick();
    chk("b2bTxStart", 0, tst[0], 1);
    waitSig(1, 1, 100, n);
    waitSig(0, 1, 20, n);
    chk("gapTxStartDelay", 1, n, GAPB + 2);
    reqValid = '0;
    waitIdle(1, 100);

    // Watchdog timeout, then normal service
    waitIdle(0, 100);
    stubLen[0] = -1;
    reqValid = 4'b0001;
    tick();
    chk("toLaunch", 0, tst[0], 1);
    reqValid = '0;
    waitSig(2, 0, TOUT + 20, n);
    chk("toDelay", 0, n, TOUT);
    tick();
    chk("toIdle", 0, bsy[0], 0);
    stubLen[0] = 5;
    reqValid = 4'b0100;
    tick();
    chk("postTimeoutGrant", 0, tst[0], 1);
    reqValid = '0;

    // txDone on the very cycle the timeout would fire
    waitIdle(0, 100);
    stubLen[0] = TOUT;
    reqValid = 4'b0010;
    tick();
    reqValid = '0;
    pulses = 0;
    repeat (TOUT + 3) begin
      tick();
      if (tmo[0]) pulses++;
    end
    chk("coincidentTimeoutErr", 0, pulses, 0);
    chk("coincidentIdle", 0, bsy[0], 0);

    // Stale txDone during LAUNCH is ignored
    waitIdle(0, 100);
    stubLen[0] = 5;
    stale[0] = 1'b1;
    reqValid = 4'b0001;
    tick();
    reqValid = '0;
    tick();
    chk("staleIgnored", 0, bsy[0], 1);
    stale[0] = 1'b0;

    // Reset in WAIT_DONE with en low afterwards
    waitIdle(0, 100);
    stubLen[0] = 30;
    reqValid = 4'b1111;
    repeat (3) tick();
    reset = 1'b1;
    en = 1'b0;
    #1;
    chk("midRstBusy", 0, bsy[0], 0);
    chk("midRstTxStart", 0, tst[0], 0);
    chk("midRstReqReady", 0, rdy[0], 0);
    chk("midRstGrantId", 0, gid[0], 0);
    chk("midRstTxByte", 0, txb[0], 0);
    chk("midRstTxEn", 0, ten[0], 0);
    chk("midRstBusyB", 1, bsy[1], 0);
    tick();
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      tick();
      if (tst[0]) n++;
    end
    chk("noGrantWhileEnLow", 0, n, 0);
    en = 1'b1;
    tick();
    chk("grantAfterEn", 0, tst[0], 1);
    chk("firstWinnerAfterRst", 0, gid[0], 0);
    reqValid = '0;

    // Randomized traffic against the model
    stubLen = '{0, 0};
    for (int c = 0; c < 3000; c++) begin
      tick();
      en       = ($urandom_range(0, 9) != 0);
      reqValid = 4'($urandom_range(0, 15));
      reqData  = $urandom;
      reset    = ($urandom_range(0, 399) == 0);
      stale    = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
    end
    reset = 1'b0;
    reqValid = '0;
    repeat (100) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
